fsm_rr_arbiter: RTL and testbench
=================================

Name: fsm_rr_arbiter

Overview:
- Four-requester round-robin arbiter that grants one shared resource, such as a bus or datapath unit, to a single owner at a time.
- Built as an explicit three-state FSM. It provides a Moore status output, a Mealy pending output and registered one-hot grants.
- Sits between requesting FSM blocks and the shared unit. It enforces a bounded hold time and one dead cycle between owners.

Parameters:
- MAX_HOLD, 16: maximum consecutive BUSY cycles per grant before a forced release. Legal range is 2..2^CNT_W.
- CNT_W, 5: width of the hold counter. Must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request lines; req[i] high means requester i wants the resource.
- done  input  4  release strobes; done[i] is honoured only while i is the owner.
- gnt  output  4  registered one-hot grant; all zeros when there is no owner.
- gnt_id  output  2  registered index of the current or most recent owner.
- busy  output  1  Moore output: high iff state == BUSY.
- pending  output  1  Mealy output: (state == IDLE) & |req.
- timeout  output  1  registered one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Async reset forces: state=IDLE, ptr=0, gnt=0, gnt_id=0, hold_cnt=0, timeout=0.
- States are IDLE=2'b00, BUSY=2'b01 and REL=2'b10. The unused code 2'b11 goes to IDLE on the next edge with gnt=0.
- ptr (2 bits) holds the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.

IDLE:
- If |req: the winner w is the first index with req set, in search order.
- Next edge: state=BUSY, gnt=1<<w, gnt_id=w, ptr=w+1 (mod 4), hold_cnt=0.
- If req==0: stay in IDLE and hold gnt at 0.
- Latency: gnt asserts exactly 1 cycle after req is sampled in IDLE.

BUSY:
- hold_cnt increments each cycle.
- A release condition is any of: done[gnt_id], !req[gnt_id], or hold_cnt==MAX_HOLD-1.
- On release, next edge: state=REL, gnt=0.
- timeout=1 for exactly that one cycle if and only if the release was caused only by the count. If done or a dropped req coincides with the count limit, the release is normal and timeout=0.
- done bits of non-owners are ignored. req changes from non-owners have no effect until the next IDLE arbitration.

REL:
- Unconditional transition to IDLE on the next edge, with gnt=0 and timeout=0.
- Guarantees at least one cycle with gnt==0 between owners.
- The minimum owner-to-owner gap is 2 cycles: one in REL, one in IDLE.

Fairness and counter rules:
- With all four req held high, grants rotate 0,1,2,3,0,...
- No requester waits more than 3 other grants.
- hold_cnt saturates and never wraps. It is cleared on every entry to BUSY.

Reset and output timing:
- Reset asserted mid-grant clears gnt asynchronously, with no REL cycle.
- After reset release, arbitration restarts from index 0.
- pending may glitch combinationally with req. Consumers sample it only on clk edges.
- gnt_id keeps the last owner while in REL and IDLE. gnt is the authoritative indicator.

Test Plan:
1. Reset, then req=4'b0100 held with done=0 → gnt=4'b0100 and gnt_id=2 one cycle later, busy=1. After 16 BUSY cycles: gnt=0, timeout=1 for one cycle, state REL, then IDLE. Re-grant to 2 occurs with ptr=3.
2. req=4'b1111 held; each owner pulses done on its 3rd BUSY cycle → grant order 0,1,2,3,0. Each grant lasts 3 cycles, followed by exactly 2 cycles of gnt=0.
3. Owner 1 in BUSY; done=4'b0100 (non-owner) → ignored, gnt stays 4'b0010. Then done=4'b0010 → release, timeout=0.
4. Owner 0 reaches its 16th BUSY cycle with done[0]=1 in the same cycle → normal release, timeout=0.
5. Owner 3 in BUSY; assert reset asynchronously mid-cycle → gnt=0, busy=0, gnt_id=0 immediately. After release, req=4'b1010 grants index 1.
6. In IDLE with req=0, check pending=0. Raise req[2] → pending=1 in the same cycle. Next edge: pending=0, busy=1.

Source files
------------

// File: rtl/fsm_rr_arbiter.sv
// fsm_rr_arbiter: four-way round-robin arbiter with bounded hold time and a dead cycle between owners
module fsm_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       pending,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, REL = 2'b10} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, gnt_id_q, gnt_id_d, win;
  logic [3:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic timeout_q, timeout_d, own_done, own_req, cnt_hit;
  always_comb begin
    win = '0;
    for (int k = 3; k >= 0; k--)
      if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
  end
  assign own_done = done[gnt_id_q];
  assign own_req  = req[gnt_id_q];
  assign cnt_hit  = hold_q == CNT_W'(MAX_HOLD - 1);
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (|req) begin
        state_d  = BUSY;
        gnt_d    = 4'b0001 << win;
        gnt_id_d = win;
        ptr_d    = win + 2'd1;
        hold_d   = '0;
      end
      BUSY: begin
        hold_d = &hold_q ? hold_q : hold_q + 1'b1;
        if (own_done || !own_req || cnt_hit) begin
          state_d   = REL;
          gnt_d     = '0;
          timeout_d = cnt_hit && own_req && !own_done;
        end
      end
      REL: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign timeout = timeout_q;
  assign busy    = state_q == BUSY;
  assign pending = (state_q == IDLE) && |req;
endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// tb_fsm_rr_arbiter: directed vectors checked against an owner/queue-level model plus literal pins
module tb_fsm_rr_arbiter;
  localparam int MAX_HOLD = 16;
  logic clk, reset;
  logic [3:0] req, done, gnt;
  logic [1:0] gnt_id;
  logic busy, pending, timeout;
  int n_vec = 0, n_err = 0;

  fsm_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .gnt(gnt),
    .gnt_id(gnt_id), .busy(busy), .pending(pending), .timeout(timeout)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Model: who owns the resource, how many busy cycles it has had, and whether we are in the dead gap
  int m_owner = -1, m_last = 0, m_ptr = 0, m_held = 0;
  bit m_rel = 0, m_to = 0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= -1; m_last <= 0; m_ptr <= 0; m_held <= 0; m_rel <= 0; m_to <= 0;
    end else if (m_owner >= 0) begin
      m_held <= m_held + 1;
      if (done[m_owner] || !req[m_owner] || m_held + 1 == MAX_HOLD) begin
        m_to    <= req[m_owner] && !done[m_owner];
        m_owner <= -1;
        m_rel   <= 1;
      end else m_to <= 0;
    end else if (m_rel) begin
      m_rel <= 0;
      m_to  <= 0;
    end else begin
      m_to <= 0;
      if (req != 0) begin
        m_owner <= pick(req, m_ptr);
        m_last  <= pick(req, m_ptr);
        m_ptr   <= (pick(req, m_ptr) + 1) % 4;
        m_held  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_gnt", gnt, m_owner >= 0 ? (1 << m_owner) : 0);
    chk("model_gnt_id", gnt_id, m_last);
    chk("model_busy", busy, m_owner >= 0);
    chk("model_pending", pending, (m_owner < 0 && !m_rel && req != 0));
    chk("model_timeout", timeout, m_to);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick(1);
    reset = 0;
  endtask

  initial begin
    reset = 1; req = 0; done = 0;
    tick(2);
    reset = 0;
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    // 1: forced release after MAX_HOLD busy cycles
    req = 4'b0100;
    tick(1);
    chk("t1_gnt", gnt, 4'b0100);
    chk("t1_id", gnt_id, 2);
    chk("t1_busy", busy, 1);
    tick(15);
    chk("t1_hold16", gnt, 4'b0100);
    tick(1);
    chk("t1_rel_gnt", gnt, 0);
    chk("t1_timeout", timeout, 1);
    tick(1);
    chk("t1_to_clear", timeout, 0);
    chk("t1_idle_pend", pending, 1);
    tick(1);
    chk("t1_regrant", gnt, 4'b0100);
    req = 0;
    tick(1);
    chk("t1_drop_to", timeout, 0);
    tick(2);
    // 2: rotation with all requesting
    pulse_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick(1);
      chk("t2_owner", gnt, 1 << (g % 4));
      tick(2);
      chk("t2_third", gnt, 1 << (g % 4));
      done = gnt;
      tick(1);
      done = 0;
      chk("t2_gap1", gnt, 0);
      if (g < 4) begin
        tick(1);
        chk("t2_gap2", gnt, 0);
      end
    end
    // 3: non-owner done ignored
    req = 4'b0010;
    tick(1);
    tick(1);
    chk("t3_owner", gnt, 4'b0010);
    done = 4'b0100;
    tick(1);
    chk("t3_ignored", gnt, 4'b0010);
    done = 4'b0010;
    tick(1);
    chk("t3_release", gnt, 0);
    chk("t3_no_to", timeout, 0);
    done = 0; req = 0;
    tick(2);
    // 4: done coincides with count limit
    req = 4'b0001;
    tick(1);
    chk("t4_owner", gnt, 4'b0001);
    tick(15);
    done = 4'b0001;
    tick(1);
    chk("t4_release", gnt, 0);
    chk("t4_no_to", timeout, 0);
    done = 0; req = 0;
    tick(2);
    // 5: asynchronous reset mid-grant
    req = 4'b1000;
    tick(1);
    chk("t5_owner", gnt, 4'b1000);
    chk("t5_id", gnt_id, 3);
    tick(2);
    #2 reset = 1;
    #1;
    chk("t5_async_gnt", gnt, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_id", gnt_id, 0);
    @(posedge clk);
    #1 reset = 0;
    req = 4'b1010;
    tick(1);
    chk("t5_restart", gnt, 4'b0010);
    chk("t5_restart_id", gnt_id, 1);
    req = 0;
    tick(3);
    // 6: Mealy pending
    chk("t6_pend0", pending, 0);
    req = 4'b0100;
    #1;
    chk("t6_pend1", pending, 1);
    tick(1);
    chk("t6_pend_busy", pending, 0);
    chk("t6_busy", busy, 1);
    req = 0;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
